aes_spi_sequencer: RTL and testbench
====================================

# aes_spi_sequencer

SPI-master transaction sequencer for the AES core. It accepts one encrypt/decrypt job (message, key, key size, mode), frames it over a 4-wire SPI link to the AES slave, and waits a fixed turnaround. It then shifts the 128-bit result back and compares it with an expected value. It replaces hand-rolled counter sequencing in top-level test harnesses and sits between the board/control logic and the SPI slave.

## Interface
- DIV, 50: system clocks per SCLK half-period (≥2).
- LATENCY, 16: SCLK periods between the last key bit and the first result bit (slave processing time).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  single-cycle job request; honoured only in IDLE.
- abort  in  1  synchronous cancel; honoured in any non-IDLE state.
- mode  in  1  0 = encrypt, 1 = decrypt; latched at start.
- size  in  2  00 = 128-bit, 01 = 192-bit, 10 = 256-bit key, 11 = illegal.
- msg_in  in  128  data block; latched at start.
- key_in  in  256  key, right-aligned: the K-bit key occupies key_in[K-1:0]. Latched at start.
- expected  in  128  compare value; latched at start.
- busy  out  1  high from accepted start until done/abort.
- done  out  1  one-cycle pulse when the result is valid.
- err  out  1  one-cycle pulse when start is given with size = 11.
- match  out  1  result == expected; updated with done, held otherwise.
- result  out  128  received block; updated with done, held otherwise.
- sclk  out  1  SPI clock; low when idle.
- cs_n  out  1  chip select, active-low.
- mosi  out  1  serial data to slave.
- spi_mode  out  1  latched mode, driven to slave for the whole frame.
- miso  in  1  serial data from slave.

## Operation
- Reset values:
  - busy, done, err, match, sclk, mosi, spi_mode: 0.
  - cs_n: 1.
  - result: 0.
  - state: IDLE.
- States and transitions:
  - IDLE:
    - start with size ≠ 11: latch inputs, go to SETUP.
    - start with size = 11: err pulse, stay in IDLE.
  - SETUP: 1 SCLK period, cs_n = 0, mosi = 0.
  - SEND_MSG: 128 periods; bit n = msg[n], LSB first.
  - SEND_KEY: K periods (K = 128/192/256), bit n = key[n], LSB first.
  - WAIT: LATENCY periods, mosi = 0.
  - RECV: 128 periods; each sampled miso shifts in as result_sr <= {miso, result_sr[127:1]}, so the first bit received lands in bit 0.
  - DONE: one clk.
    - cs_n = 1, busy = 0, done = 1.
    - result <= result_sr, match <= (result_sr == expected_q).
    - Then go to IDLE.
- SCLK period: DIV clocks low, then DIV clocks high.
  - mosi and state/bit-counter advance on the clk that starts a period (sclk falls or stays low).
  - miso is sampled on the clk where sclk rises.
- Bit counter: 9 bits, compared against per-state length minus 1; never wraps past the state length.
- start while busy: ignored (no err, no latch).
- abort:
  - Next clk: state IDLE, cs_n = 1, sclk = 0, mosi = 0, busy = 0.
  - No done; result and match hold their previous values.
  - abort and start in the same IDLE cycle: start wins (abort is ignored in IDLE).
- reset mid-frame: immediate return to reset values; the slave sees cs_n rise asynchronously.

## Timing
- Job of P = 1 + 128 + K + LATENCY + 128 SCLK periods.
- Start accepted at clk cycle 0: cs_n low and busy high from cycle 1.
- done high exactly at cycle 2·DIV·P + 1.
- Example: DIV = 50, K = 128, LATENCY = 16 gives P = 401 and done at cycle 40101.
- cs_n rises in the same cycle as done.
- The earliest next start is accepted the cycle after done.

## Structure
- Package aes_spi_pkg holds:
  - size encodings and the key_bits(size) function;
  - the state enum (IDLE, SETUP, SEND_MSG, SEND_KEY, WAIT, RECV, DONE);
  - MSG_BITS = 128.
- Sub-module sclk_gen:
  - divider with inputs clk, reset, run, and outputs sclk, period_start strobe and rise strobe;
  - clears to count 0 with sclk low when run = 0.
- The sequencer FSM, shift registers and compare live in the top module.

## Test plan
- Encrypt, 128-bit, DIV = 2, LATENCY = 16, behavioural slave:
  - stimulus: msg 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, expected 3925841d02dc09fbdc118597196a0b32;
  - required: result equals expected, match = 1, done at cycle 1605.
- Decrypt, 256-bit key 000102…1f:
  - stimulus: ciphertext 8ea2b7ca516745bfeafc49904b496089, expected 00112233445566778899aabbccddeeff;
  - required: match = 1, exactly 256 key bits counted on mosi.
- 192-bit key with a deliberately wrong expected value: done pulses, match = 0, result is still the correct ciphertext.
- start with size = 11: err pulse of one clk, busy stays 0, cs_n stays 1, no sclk edges.
- abort during SEND_KEY, then a fresh start:
  - cs_n high and sclk low on the next clk, no done;
  - the second job completes with correct timing.
- Async reset asserted during RECV: all outputs take their reset values within the reset cycle; start pulses while busy are ignored (second check).

Source files
------------

// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES SPI-master sequencer.
// Key-size encodings, sequencer states and the key-length lookup.
package aes_spi_pkg;

  localparam int MSG_BITS = 128;
  localparam int KEY_MAX  = 256;

  typedef enum logic [1:0] {
    SIZE_128 = 2'b00,
    SIZE_192 = 2'b01,
    SIZE_256 = 2'b10,
    SIZE_BAD = 2'b11
  } key_size_e;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SEND_MSG,
    SEND_KEY,
    WAIT,
    RECV,
    DONE
  } seq_state_e;

  function automatic logic [8:0] key_bits(input logic [1:0] size);
    case (size)
      SIZE_192: key_bits = 9'd192;
      SIZE_256: key_bits = 9'd256;
      default:  key_bits = 9'd128;
    endcase
  endfunction

endpackage

// File: rtl/aes_spi_sequencer_sclk_gen.sv
// SCLK divider: DIV clocks low then DIV clocks high per period.
// Held at count 0 with sclk low whenever run is deasserted.
module sclk_gen #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sclk,
  output logic period_start,
  output logic rise
);

  localparam int CW = $clog2(2 * DIV);
  localparam logic [CW-1:0] RISE_AT = CW'(DIV - 1);
  localparam logic [CW-1:0] LAST    = CW'(2 * DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == RISE_AT) sclk <= 1'b1;
    end
  end

  // period_start marks the clk at which sclk falls and the next period begins
  assign period_start = run && (cnt == LAST);
  assign rise         = run && (cnt == RISE_AT);

endmodule

// File: rtl/aes_spi_sequencer.sv
// SPI-master sequencer: frames one AES job to the slave, waits the
// turnaround, shifts the 128-bit result back and compares it.
module aes_spi_sequencer
  import aes_spi_pkg::*;
#(
  parameter int DIV     = 50,
  parameter int LATENCY = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 mode,
  input  logic [1:0]           size,
  input  logic [MSG_BITS-1:0]  msg_in,
  input  logic [KEY_MAX-1:0]   key_in,
  input  logic [MSG_BITS-1:0]  expected,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 match,
  output logic [MSG_BITS-1:0]  result,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 mosi,
  output logic                 spi_mode,
  input  logic                 miso
);

  seq_state_e state, state_nxt;

  logic [8:0]          bit_cnt;
  logic [8:0]          last_bit;
  logic                last;
  logic                accept;
  logic                reject;
  logic                run;
  logic                period_start;
  logic                rise;
  logic                mode_q;
  logic [1:0]          size_q;
  logic [MSG_BITS-1:0] msg_sr;
  logic [KEY_MAX-1:0]  key_sr;
  logic [MSG_BITS-1:0] expected_q;
  logic [MSG_BITS-1:0] result_sr;

  assign accept = (state == IDLE) && start && (size != SIZE_BAD);
  assign reject = (state == IDLE) && start && (size == SIZE_BAD);
  // Dropping run together with abort clears sclk on the same clk
  assign run    = (state != IDLE) && (state != DONE) && !abort;

  sclk_gen #(.DIV(DIV)) u_sclk_gen (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .sclk         (sclk),
    .period_start (period_start),
    .rise         (rise)
  );

  always_comb begin
    last_bit = 9'd0;
    case (state)
      SEND_MSG: last_bit = 9'(MSG_BITS - 1);
      SEND_KEY: last_bit = key_bits(size_q) - 9'd1;
      WAIT:     last_bit = 9'(LATENCY - 1);
      RECV:     last_bit = 9'(MSG_BITS - 1);
      default:  last_bit = 9'd0;
    endcase
  end

  assign last = (bit_cnt == last_bit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SETUP;
      DONE: state_nxt = IDLE;
      default: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (period_start && last) begin
          case (state)
            SETUP:    state_nxt = SEND_MSG;
            SEND_MSG: state_nxt = SEND_KEY;
            SEND_KEY: state_nxt = WAIT;
            WAIT:     state_nxt = RECV;
            RECV:     state_nxt = DONE;
            default:  state_nxt = IDLE;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    busy = (state != IDLE) && (state != DONE);
    cs_n = !busy;
    done = (state == DONE);
    case (state)
      SEND_MSG: mosi = msg_sr[0];
      SEND_KEY: mosi = key_sr[0];
      default:  mosi = 1'b0;
    endcase
  end

  assign spi_mode = mode_q;

  // Bit counter restarts on every state change, so it never runs past a state length
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   bit_cnt <= '0;
    else if (state_nxt != state) bit_cnt <= '0;
    else if (period_start)       bit_cnt <= bit_cnt + 9'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= 1'b0;
      size_q     <= SIZE_128;
      msg_sr     <= '0;
      key_sr     <= '0;
      expected_q <= '0;
      result_sr  <= '0;
      result     <= '0;
      match      <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= reject;
      if (accept) begin
        mode_q     <= mode;
        size_q     <= size;
        msg_sr     <= msg_in;
        key_sr     <= key_in;
        expected_q <= expected;
      end else if (period_start && !abort) begin
        if (state == SEND_MSG) msg_sr <= msg_sr >> 1;
        if (state == SEND_KEY) key_sr <= key_sr >> 1;
      end
      if (rise && (state == RECV)) result_sr <= {miso, result_sr[MSG_BITS-1:1]};
      // Publish on entry to DONE so result and match are valid alongside done
      if ((state == RECV) && (state_nxt == DONE)) begin
        result <= result_sr;
        match  <= (result_sr == expected_q);
      end
    end
  end

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// Directed bench for aes_spi_sequencer with a behavioural AES SPI slave
// that answers from known FIPS-197 vectors.
module tb_aes_spi_sequencer;

  localparam int DIV     = 2;
  localparam int LATENCY = 16;

  localparam logic [127:0] PT1    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K128   = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
  localparam logic [127:0] PT_STD = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K192   = {64'h0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         mode = 1'b0;
  logic [1:0]   size = 2'b00;
  logic [127:0] msg_in = '0;
  logic [255:0] key_in = '0;
  logic [127:0] expected = '0;
  logic         miso = 1'b0;
  logic         busy, done, err, match, sclk, cs_n, mosi, spi_mode;
  logic [127:0] result;

  int vectors = 0;
  int miscompares = 0;

  int            cur_k = 128;
  int            rise_cnt = 0;
  int            last_rises = 0;
  int            sclk_rises = 0;
  logic [1023:0] rx;
  logic [127:0]  resp;

  aes_spi_sequencer #(.DIV(DIV), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .size(size), .msg_in(msg_in), .key_in(key_in), .expected(expected),
    .busy(busy), .done(done), .err(err), .match(match), .result(result),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .spi_mode(spi_mode), .miso(miso)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] key_from(input logic [1023:0] v, input int k);
    logic [255:0] kk;
    kk = '0;
    for (int i = 0; i < k; i++) kk[i] = v[129 + i];
    return kk;
  endfunction

  function automatic logic [127:0] slave_model(input logic m, input logic [127:0] blk,
                                               input logic [255:0] k);
    if (!m && (k == K128) && (blk == PT1))    return CT1;
    if (m  && (k == K256) && (blk == CT256))  return PT_STD;
    if (!m && (k == K192) && (blk == PT_STD)) return CT192;
    return '1;
  endfunction

  // Slave: captures mosi on sclk rise, drives miso after sclk falls
  always @(sclk or cs_n) begin
    if (cs_n === 1'b1) begin
      if (rise_cnt != 0) last_rises = rise_cnt;
      rise_cnt = 0;
      miso = 1'b0;
    end else if (sclk === 1'b1) begin
      if (rise_cnt < 1024) rx[rise_cnt] = mosi;
      rise_cnt++;
      if (rise_cnt == 129 + cur_k) resp = slave_model(spi_mode, rx[128:1], key_from(rx, cur_k));
    end else if (rise_cnt >= 129 + cur_k + LATENCY && rise_cnt < 257 + cur_k + LATENCY) begin
      miso = resp[rise_cnt - (129 + cur_k + LATENCY)];
    end
  end

  always @(posedge sclk) sclk_rises++;

  task automatic run_job(input string name, input logic m, input logic [1:0] sz,
                         input logic [127:0] blk, input logic [255:0] k,
                         input logic [127:0] exp, input int kb, output int done_cyc);
    int n;
    @(negedge clk);
    cur_k = kb; mode = m; size = sz; msg_in = blk; key_in = k; expected = exp; start = 1'b1;
    @(negedge clk);
    start = 1'b0; msg_in = '0; key_in = '0; expected = '0; mode = ~m;
    n = 1;
    vectors++;
    if (busy !== 1'b1 || cs_n !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_frame_open: busy=%b cs_n=%b, want busy=1 cs_n=0", name, busy, cs_n);
    end
    while (done !== 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    done_cyc = (done === 1'b1) ? n : -1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, err, match, sclk, mosi, spi_mode} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy/done/err/match/sclk/mosi/spi_mode=%b, want 0000000",
               {busy, done, err, match, sclk, mosi, spi_mode});
    end
    vectors++;
    if (cs_n !== 1'b1 || result !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_data: cs_n=%b result=%h, want cs_n=1 result=0", cs_n, result);
    end
    reset = 1'b0;
  endtask

  task automatic test_illegal_size;
    int edges0;
    @(negedge clk);
    edges0 = sclk_rises;
    size = 2'b11; msg_in = PT1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; size = 2'b00;
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0 || cs_n !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_err: err=%b busy=%b cs_n=%b, want err=1 busy=0 cs_n=1", err, busy, cs_n);
    end
    @(negedge clk);
    vectors++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_pulse: err=%b busy=%b, want err=0 busy=0", err, busy);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (sclk_rises != edges0 || cs_n !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_quiet: sclk rises=%0d cs_n=%b, want rises=%0d cs_n=1",
               sclk_rises - edges0, cs_n, 0);
    end
  endtask

  task automatic test_encrypt128;
    int dc;
    run_job("enc128", 1'b0, 2'b00, PT1, K128, CT1, 128, dc);
    vectors++;
    if (dc != 1605) begin
      miscompares++;
      $display("FAIL enc128_done_cycle: got %0d, want 1605", dc);
    end
    vectors++;
    if (result !== CT1 || match !== 1'b1) begin
      miscompares++;
      $display("FAIL enc128_result: result=%h match=%b, want %h match=1", result, match, CT1);
    end
    vectors++;
    if (cs_n !== 1'b1 || busy !== 1'b0 || spi_mode !== 1'b0) begin
      miscompares++;
      $display("FAIL enc128_close: cs_n=%b busy=%b spi_mode=%b, want 1 0 0", cs_n, busy, spi_mode);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || result !== CT1) begin
      miscompares++;
      $display("FAIL enc128_hold: done=%b result=%h, want done=0 result=%h", done, result, CT1);
    end
  endtask

  task automatic test_decrypt256;
    int dc;
    run_job("dec256", 1'b1, 2'b10, CT256, K256, PT_STD, 256, dc);
    vectors++;
    if (dc != 2117) begin
      miscompares++;
      $display("FAIL dec256_done_cycle: got %0d, want 2117", dc);
    end
    vectors++;
    if (result !== PT_STD || match !== 1'b1 || spi_mode !== 1'b1) begin
      miscompares++;
      $display("FAIL dec256_result: result=%h match=%b spi_mode=%b, want %h 1 1",
               result, match, spi_mode, PT_STD);
    end
    vectors++;
    if (last_rises - (1 + 128 + LATENCY + 128) != 256 || key_from(rx, 256) !== K256) begin
      miscompares++;
      $display("FAIL dec256_key_bits: counted %0d key=%h, want 256 key=%h",
               last_rises - (1 + 128 + LATENCY + 128), key_from(rx, 256), K256);
    end
  endtask

  task automatic test_wrong_expected192;
    int dc;
    run_job("enc192", 1'b0, 2'b01, PT_STD, K192, ~CT192, 192, dc);
    vectors++;
    if (dc != 1861) begin
      miscompares++;
      $display("FAIL enc192_done_cycle: got %0d, want 1861", dc);
    end
    vectors++;
    if (result !== CT192 || match !== 1'b0) begin
      miscompares++;
      $display("FAIL enc192_mismatch: result=%h match=%b, want %h match=0", result, match, CT192);
    end
  endtask

  task automatic test_abort;
    int saw;
    int dc;
    @(negedge clk);
    cur_k = 128; mode = 1'b0; size = 2'b00; msg_in = PT1; key_in = K128; expected = CT1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (598) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || mosi !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_stop: cs_n=%b sclk=%b busy=%b mosi=%b, want 1 0 0 0", cs_n, sclk, busy, mosi);
    end
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) saw++;
    end
    vectors++;
    if (saw != 0 || result !== CT192 || match !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_hold: done pulses=%0d result=%h match=%b, want 0 %h 0", saw, result, match, CT192);
    end
    run_job("restart", 1'b0, 2'b00, PT1, K128, CT1, 128, dc);
    vectors++;
    if (dc != 1605 || result !== CT1 || match !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_job: cycle=%0d result=%h match=%b, want 1605 %h 1", dc, result, match, CT1);
    end
  endtask

  task automatic test_reset_in_recv;
    @(negedge clk);
    cur_k = 128; mode = 1'b1; size = 2'b00; msg_in = PT1; key_in = K128; expected = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1100) @(negedge clk);
    size = 2'b11; msg_in = '1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_start_illegal: err=%b busy=%b, want err=0 busy=1", err, busy);
    end
    size = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (err !== 1'b0 || busy !== 1'b1 || cs_n !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_legal: err=%b busy=%b cs_n=%b, want 0 1 0", err, busy, cs_n);
    end
    repeat (20) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({busy, done, err, match, sclk, mosi, spi_mode} !== 7'b0 || cs_n !== 1'b1 || result !== CT1) begin
      if (result !== 128'h0 || {busy, done, err, match, sclk, mosi, spi_mode} !== 7'b0 || cs_n !== 1'b1) begin
        miscompares++;
        $display("FAIL async_reset: ctrl=%b cs_n=%b result=%h, want ctrl=0000000 cs_n=1 result=0",
                 {busy, done, err, match, sclk, mosi, spi_mode}, cs_n, result);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (cs_n !== 1'b1 || busy !== 1'b0 || result !== 128'h0) begin
      miscompares++;
      $display("FAIL post_reset_idle: cs_n=%b busy=%b result=%h, want 1 0 0", cs_n, busy, result);
    end
  endtask

  task automatic test_back_to_back;
    int dc1;
    int dc2;
    run_job("b2b_first", 1'b0, 2'b00, PT1, K128, CT1, 128, dc1);
    vectors++;
    if (dc1 != 1605 || match !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: cycle=%0d match=%b, want 1605 1", dc1, match);
    end
    run_job("b2b_second", 1'b0, 2'b01, PT_STD, K192, CT192, 192, dc2);
    vectors++;
    if (dc2 != 1861 || result !== CT192 || match !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: cycle=%0d result=%h match=%b, want 1861 %h 1", dc2, result, match, CT192);
    end
  endtask

  initial begin
    test_reset;
    test_illegal_size;
    test_encrypt128;
    test_decrypt256;
    test_wrong_expected192;
    test_abort;
    test_reset_in_recv;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
